// File: rtl/battleship_game_ctrl.sv
// rtl/battleship_game_ctrl.sv - game-flow sequencer for the battleship board
//
// Purpose: owns the attack bitmap and cursor, sequences placement/attack/view
// modes, scores shots against the placement map and drives status codes,
// hit/miss RGB and the win/lose flag.
//
// Optional feature macro: SHOT_LIMIT_EN (shot budget of MAX_SHOTS; LOST
// reachable). Undefined: unlimited shots, shots_left tied to 0.
//
// Ports:
//   clk, clr_n              clock, asynchronous active-low reset
//   mode                    00 idle, 01 placement, 10 attack, 11 view
//   btn_confirm, btn_count  debounced button levels (rising edge used)
//   ship_map                placement matrix, bit index = col*NUM_ROWS+row
//   po_load, po_clr         one-cycle placement register load / clear pulses
//   atk_map                 attacked-cell bitmap, same indexing as ship_map
//   cursor_col, cursor_row  attack cursor
//   status                  display status code
//   ships_left, shots_left  unhit ship cells / remaining shot budget
//   result_rgb              10 hit, 01 miss, 00 otherwise
//   game_over               high in WON or LOST
module battleship_game_ctrl #(
  parameter int NUM_COLS    = 5,
  parameter int NUM_ROWS    = 7,
  parameter int RESULT_HOLD = 1024,
  parameter int MAX_SHOTS   = 20
) (
  input  logic                         clk,
  input  logic                         clr_n,
  input  logic [1:0]                   mode,
  input  logic                         btn_confirm,
  input  logic                         btn_count,
  input  logic [NUM_COLS*NUM_ROWS-1:0] ship_map,
  output logic                         po_load,
  output logic                         po_clr,
  output logic [NUM_COLS*NUM_ROWS-1:0] atk_map,
  output logic [2:0]                   cursor_col,
  output logic [2:0]                   cursor_row,
  output logic [3:0]                   status,
  output logic [5:0]                   ships_left,
  output logic [5:0]                   shots_left,
  output logic [1:0]                   result_rgb,
  output logic                         game_over
);

`ifdef SHOT_LIMIT_EN
  localparam bit SHOT_LIMIT = 1'b1;
`else
  localparam bit SHOT_LIMIT = 1'b0;
`endif
  localparam logic [5:0] SHOTS_INIT = SHOT_LIMIT ? 6'(MAX_SHOTS) : 6'd0;
  localparam int         HW         = $clog2(RESULT_HOLD + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PLACE, S_SELECT, S_CHECK, S_RESULT, S_WON, S_LOST, S_VIEW
  } state_t;

  state_t        state, next_state;
  logic          confirm_prev, count_prev;
  logic          confirm_pulse, count_pulse;
  logic          load_pend;
  logic [HW-1:0] hold_cnt;
  logic          hold_done;
  logic [5:0]    idx;
  logic          already, hit;
  logic          shots_out;
  logic          enter_idle;

  assign confirm_pulse = btn_confirm & ~confirm_prev;
  assign count_pulse   = btn_count & ~count_prev;
  assign idx           = 6'(cursor_col) * 6'(NUM_ROWS) + 6'(cursor_row);
  assign already       = atk_map[idx];
  assign hit           = ship_map[idx];
  assign hold_done     = (hold_cnt == HW'(RESULT_HOLD - 1));
  assign shots_out     = SHOT_LIMIT && (shots_left == 6'd0);
  assign enter_idle    = (next_state == S_IDLE) && (state != S_IDLE);
  assign game_over     = (state == S_WON) || (state == S_LOST);

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:   if (mode == 2'b01) next_state = S_PLACE;
                else if (mode == 2'b11) next_state = S_VIEW;
      S_PLACE:  if (mode == 2'b00) next_state = S_IDLE;
                else if (mode == 2'b10 && ships_left != 6'd0) next_state = S_SELECT;
      S_SELECT: if (mode != 2'b10) next_state = S_IDLE;
                else if (confirm_pulse) next_state = S_CHECK;
      S_CHECK:  next_state = (mode != 2'b10) ? S_IDLE : S_RESULT;
      S_RESULT: if (mode != 2'b10) next_state = S_IDLE;
                else if (hold_done) begin
                  if (ships_left == 6'd0) next_state = S_WON;
                  else if (shots_out) next_state = S_LOST;
                  else next_state = S_SELECT;
                end
      S_WON, S_LOST: if (mode == 2'b00) next_state = S_IDLE;
      S_VIEW:   if (mode == 2'b00) next_state = S_IDLE;
                else if (mode == 2'b01) next_state = S_PLACE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state        <= S_IDLE;
      confirm_prev <= 1'b0;
      count_prev   <= 1'b0;
      load_pend    <= 1'b0;
      po_load      <= 1'b0;
      po_clr       <= 1'b0;
      hold_cnt     <= '0;
      atk_map      <= '0;
      cursor_col   <= 3'd0;
      cursor_row   <= 3'd0;
      ships_left   <= 6'd0;
      shots_left   <= SHOTS_INIT;
      status       <= 4'd0;
      result_rgb   <= 2'b00;
    end else begin
      state        <= next_state;
      confirm_prev <= btn_confirm;
      count_prev   <= btn_count;
      po_load      <= (state == S_PLACE) && (next_state == S_PLACE) && confirm_pulse;
      // Placement register output is valid the cycle after po_load.
      load_pend    <= po_load;
      po_clr       <= enter_idle;
      hold_cnt     <= (state == S_RESULT && next_state == S_RESULT) ? hold_cnt + 1'b1 : '0;

      // Clearing while resident in IDLE lets an aborted CHECK still commit
      // its bitmap update on the abort edge before the board is wiped.
      if (state == S_IDLE) begin
        atk_map    <= '0;
        cursor_col <= 3'd0;
        cursor_row <= 3'd0;
        ships_left <= 6'd0;
        shots_left <= SHOTS_INIT;
      end

      if (state == S_PLACE && load_pend)
        ships_left <= 6'($countones(ship_map));

      // Confirm wins over count: a leaving SELECT never moves the cursor.
      if (state == S_SELECT && next_state == S_SELECT && count_pulse) begin
        if (cursor_row == 3'(NUM_ROWS - 1)) begin
          cursor_row <= 3'd0;
          cursor_col <= (cursor_col == 3'(NUM_COLS - 1)) ? 3'd0 : cursor_col + 3'd1;
        end else begin
          cursor_row <= cursor_row + 3'd1;
        end
      end

      if (state == S_CHECK && !already) begin
        atk_map[idx] <= 1'b1;
        if (hit) ships_left <= ships_left - 6'd1;
        if (SHOT_LIMIT && shots_left != 6'd0) shots_left <= shots_left - 6'd1;
      end

      case (next_state)
        S_IDLE:   status <= 4'd0;
        S_PLACE:  status <= 4'd1;
        S_SELECT: status <= 4'd2;
        S_CHECK:  status <= 4'd2;
        S_RESULT: if (state == S_CHECK) status <= already ? 4'd5 : (hit ? 4'd3 : 4'd4);
        S_WON:    status <= 4'd6;
        S_LOST:   status <= 4'd7;
        S_VIEW:   status <= 4'd8;
        default:  status <= 4'd0;
      endcase

      if (state == S_CHECK && next_state == S_RESULT)
        result_rgb <= already ? 2'b00 : (hit ? 2'b10 : 2'b01);
      else if (next_state != S_RESULT)
        result_rgb <= 2'b00;
    end
  end

endmodule
